// File: rtl/card_match_engine.sv
`default_nettype none
// ============================================================================
//  Module      : card_match_engine
//  Description : Game core for the memory (concentration) card game on a
//                GRID_W x GRID_H grid. Holds the deck, accepts two picks from
//                the cursor, compares them, keeps a mismatched pair face-up
//                for SHOW_CYCLES+1 cycles, and tracks pairs, moves and game
//                over.
//  Ports       : clock, reset (async, active-high)
//                start, select, cursor         - game control from the UI
//                deck_we, deck_waddr, deck_wdata - deck load (IDLE/DONE only)
//                face_up, matched              - per-card display state
//                card1, card2                  - face values of current picks
//                pair_count, move_count        - score counters
//                game_over, state              - game status
//  Revision    : 1.0 - initial release
// ============================================================================
module card_match_engine #(
    parameter  int GRID_W      = 6,
    parameter  int GRID_H      = 6,
    parameter  int ID_W        = 5,
    parameter  int SHOW_CYCLES = 25_000_000,
    parameter  int MOVE_W      = 8,
    localparam int N           = GRID_W * GRID_H,
    localparam int IDX_W       = $clog2(N),
    localparam int PAIR_W      = $clog2(N / 2 + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              select,
    input  logic [IDX_W-1:0]  cursor,
    input  logic              deck_we,
    input  logic [IDX_W-1:0]  deck_waddr,
    input  logic [ID_W-1:0]   deck_wdata,
    output logic [N-1:0]      face_up,
    output logic [N-1:0]      matched,
    output logic [ID_W-1:0]   card1,
    output logic [ID_W-1:0]   card2,
    output logic [PAIR_W-1:0] pair_count,
    output logic [MOVE_W-1:0] move_count,
    output logic              game_over,
    output logic [2:0]        state
);

    localparam int TMR_W = $clog2(SHOW_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PICK1   = 3'd1,
        S_PICK2   = 3'd2,
        S_COMPARE = 3'd3,
        S_SHOW    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_deck [N];
    logic [N-1:0]       r_face_up, w_face_up_nxt;
    logic [N-1:0]       r_matched, w_matched_nxt;
    logic [ID_W-1:0]    r_card1, w_card1_nxt;
    logic [ID_W-1:0]    r_card2, w_card2_nxt;
    logic [IDX_W-1:0]   r_idx1, w_idx1_nxt;
    logic [IDX_W-1:0]   r_idx2, w_idx2_nxt;
    logic [PAIR_W-1:0]  r_pair_count, w_pair_nxt;
    logic [MOVE_W-1:0]  r_move_count, w_move_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic               r_game_over;

    // A pick is only legal on an in-range, not-yet-matched card.
    logic w_pick_ok;
    logic w_deck_wr;
    assign w_pick_ok = select && (32'(cursor) < 32'(N)) && !r_matched[cursor];
    assign w_deck_wr = deck_we && (32'(deck_waddr) < 32'(N))
                       && (r_state == S_IDLE || r_state == S_DONE);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_face_up_nxt = r_face_up;
        w_matched_nxt = r_matched;
        w_card1_nxt   = r_card1;
        w_card2_nxt   = r_card2;
        w_idx1_nxt    = r_idx1;
        w_idx2_nxt    = r_idx2;
        w_pair_nxt    = r_pair_count;
        w_move_nxt    = r_move_count;
        w_timer_nxt   = r_timer;

        if (start) begin
            // start has priority over select in every state
            w_state_nxt   = S_PICK1;
            w_face_up_nxt = '0;
            w_matched_nxt = '0;
            w_card1_nxt   = '0;
            w_card2_nxt   = '0;
            w_pair_nxt    = '0;
            w_move_nxt    = '0;
            w_timer_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    w_state_nxt = r_state;
                end
                S_PICK1: begin
                    if (w_pick_ok) begin
                        w_face_up_nxt[cursor] = 1'b1;
                        w_idx1_nxt            = cursor;
                        w_card1_nxt           = r_deck[cursor];
                        w_card2_nxt           = '0;
                        w_state_nxt           = S_PICK2;
                    end
                end
                S_PICK2: begin
                    if (w_pick_ok && cursor != r_idx1) begin
                        w_face_up_nxt[cursor] = 1'b1;
                        w_idx2_nxt            = cursor;
                        w_card2_nxt           = r_deck[cursor];
                        w_state_nxt           = S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (r_move_count != '1) begin
                        w_move_nxt = r_move_count + 1'b1;
                    end
                    if (r_card1 == r_card2) begin
                        w_matched_nxt[r_idx1] = 1'b1;
                        w_matched_nxt[r_idx2] = 1'b1;
                        w_face_up_nxt[r_idx1] = 1'b0;
                        w_face_up_nxt[r_idx2] = 1'b0;
                        w_pair_nxt            = r_pair_count + 1'b1;
                        if (32'(r_pair_count) + 32'd1 == 32'(N / 2)) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_PICK1;
                        end
                    end else begin
                        w_timer_nxt = TMR_W'(SHOW_CYCLES - 1);
                        w_state_nxt = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (r_timer == '0) begin
                        w_face_up_nxt[r_idx1] = 1'b0;
                        w_face_up_nxt[r_idx2] = 1'b0;
                        w_card1_nxt           = '0;
                        w_card2_nxt           = '0;
                        w_state_nxt           = S_PICK1;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_face_up    <= '0;
            r_matched    <= '0;
            r_card1      <= '0;
            r_card2      <= '0;
            r_idx1       <= '0;
            r_idx2       <= '0;
            r_pair_count <= '0;
            r_move_count <= '0;
            r_timer      <= '0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_face_up    <= w_face_up_nxt;
            r_matched    <= w_matched_nxt;
            r_card1      <= w_card1_nxt;
            r_card2      <= w_card2_nxt;
            r_idx1       <= w_idx1_nxt;
            r_idx2       <= w_idx2_nxt;
            r_pair_count <= w_pair_nxt;
            r_move_count <= w_move_nxt;
            r_timer      <= w_timer_nxt;
            r_game_over  <= (w_state_nxt == S_DONE);
        end
    end

    // Deck storage: writable only while no game is in progress
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_deck[i] <= '0;
            end
        end else if (w_deck_wr) begin
            r_deck[deck_waddr] <= deck_wdata;
        end
    end

    assign face_up    = r_face_up;
    assign matched    = r_matched;
    assign card1      = r_card1;
    assign card2      = r_card2;
    assign pair_count = r_pair_count;
    assign move_count = r_move_count;
    assign game_over  = r_game_over;
    assign state      = r_state;

endmodule
`default_nettype wire
